// File: rtl/serial_word_collector_pkg.sv
// Shared definitions for the serial word collector: output FSM encoding and
// the counter-width helper used by the top level and the shifter.
package serial_word_collector_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Width of a counter that can represent 0..width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_word_collector_sipo.sv
// Serial-in/parallel-out stage: shift register plus modulo-WIDTH bit counter.
// word/done expose the word as it will look after this edge, so the consumer
// can capture a completed word on its completion edge with no extra latency.
module sipo_shifter
    import serial_word_collector_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             data_in,
    output logic [WIDTH-1:0] word,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_bit;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    generate
        if (MSB_FIRST) begin : g_msb
            always_comb begin
                shift_d = shift_q;
                if (enable) shift_d = {shift_q[WIDTH-2:0], data_in};
            end
        end else begin : g_lsb
            always_comb begin
                shift_d = shift_q;
                if (enable) shift_d = {data_in, shift_q[WIDTH-1:1]};
            end
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (enable) cnt_d = last_bit ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word  = shift_d;
    assign count = cnt_q;
    assign done  = enable && last_bit;

endmodule

// File: rtl/serial_word_collector.sv
// Serial bit collector with a double-buffered, valid/ack word output.
// The shifter keeps collecting while the output register holds a word.
module serial_word_collector
    import serial_word_collector_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       data_in,
    input  logic                       ack,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid,
    output logic [cnt_w(WIDTH)-1:0]    bit_count,
    output logic                       overrun
);

    localparam int CNT_W = cnt_w(WIDTH);

    logic [WIDTH-1:0] word;
    logic             done;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic             ovr_q;
    logic             load, drop;

    sipo_shifter #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST),
        .CNT_W    (CNT_W)
    ) u_sipo (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .data_in(data_in),
        .word   (word),
        .count  (bit_count),
        .done   (done)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (done) state_d = FULL;
            FULL:    if (ack && !done) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // A completion while FULL is only accepted if the held word leaves on the same edge.
    always_comb begin
        load = 1'b0;
        drop = 1'b0;
        case (state_q)
            EMPTY:   load = done;
            FULL: begin
                load = done && ack;
                drop = done && !ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            if (load) data_q <= word;
            if (drop) ovr_q  <= 1'b1;
        end
    end

    assign data_out = data_q;
    assign valid    = (state_q == FULL);
    assign overrun  = ovr_q;

endmodule
